// File: rtl/bridge_pkg.sv
// Shared definitions for the Pr* bus bridge and its countdown timer.
// Holds the default address map, timer register offsets, the timer FSM
// state type and the layout of the CTRL register.
package bridge_pkg;

    localparam logic [29:0] TIMER_BASE_DFLT = 30'h1FC0;  // byte 0x7F00
    localparam logic [29:0] DEV_BASE_DFLT   = 30'h1FC4;  // byte 0x7F10

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} type_timer_state;

    // CTRL[3]=IM, CTRL[2:1]=Mode, CTRL[0]=En
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } type_timer_ctrl;

endpackage

// File: rtl/io_bridge_timer_core.sv
// Countdown timer: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT FSM
// and the pending-interrupt flag.
// Ports: clk, reset (async, active-high); ctrl_we/preset_we/wd from the
// bus decode; ctrl/preset/count register values for readback; irq.
module timer_core
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic        preset_we,
    input  logic [31:0] wd,
    output logic [3:0]  ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);

    type_timer_state state, state_nxt;
    type_timer_ctrl  ctrl_q, ctrl_nxt;
    logic [31:0]     count_nxt;
    logic            irq_nxt;
    logic            wr_dis;

    assign ctrl   = ctrl_q;
    // A CTRL write clearing En while counting stops the FSM on the same edge
    assign wr_dis = ctrl_we & ~wd[0];

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = ctrl_q;
        count_nxt = count;
        irq_nxt   = irq;
        if (ctrl_we) begin
            ctrl_nxt = type_timer_ctrl'(wd[3:0]);
            irq_nxt  = 1'b0;
        end
        case (state)
            IDLE: if (ctrl_q.en) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl_q.en) begin
                    state_nxt = IDLE;
                end else if (count <= 32'd1) begin
                    // terminal count wins over a same-cycle CTRL write
                    count_nxt = '0;
                    irq_nxt   = 1'b1;
                    state_nxt = INT;
                end else if (wr_dis) begin
                    state_nxt = IDLE;              // COUNT frozen
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            INT: begin
                if (ctrl_q.mode == 2'd1) begin
                    irq_nxt   = 1'b0;              // auto-reload: one-cycle pulse
                    state_nxt = LOAD;
                end else begin
                    ctrl_nxt.en = 1'b0;            // one-shot: overrides any write
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ctrl_q <= '0;
            preset <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_nxt;
            count  <= count_nxt;
            irq    <= irq_nxt;
            if (preset_we) preset <= wd;
        end
    end

endmodule

// File: rtl/io_bridge_timer.sv
// System-side responder for the CPU Pr* bus: decodes PrAddr into the
// timer registers or the external device window, muxes read data and
// assembles HWInt[7:2] = {ext_int, timer irq & IM}.
// Ports: clk, reset; Pr* bus (PrAddr, PrWD, PrBE, IOWrite, IORead, PrRD,
// HWInt); ext_int; device window passthrough (dev_addr, dev_wd, dev_be,
// dev_we, dev_re, dev_rd). DEV_BASE must be aligned to DEV_WORDS.
module io_bridge_timer
    import bridge_pkg::*;
#(
    parameter logic [29:0] TIMER_BASE = TIMER_BASE_DFLT,
    parameter logic [29:0] DEV_BASE   = DEV_BASE_DFLT,
    parameter int          DEV_WORDS  = 4,
    localparam int         DEV_AW     = (DEV_WORDS > 1) ? $clog2(DEV_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       PrAddr,
    input  logic [31:0]       PrWD,
    input  logic [3:0]        PrBE,
    input  logic              IOWrite,
    input  logic              IORead,
    output logic [31:0]       PrRD,
    output logic [5:0]        HWInt,
    input  logic [4:0]        ext_int,
    output logic [DEV_AW-1:0] dev_addr,
    output logic [31:0]       dev_wd,
    output logic [3:0]        dev_be,
    output logic              dev_we,
    output logic              dev_re,
    input  logic [31:0]       dev_rd
);

    logic [29:0] t_ofs, d_ofs;
    logic        timer_hit, dev_hit, full_word;
    logic [3:0]  ctrl;
    logic [31:0] preset, count;
    logic        irq;

    // Offsets wrap below the base, so a single unsigned compare is a range check
    assign t_ofs     = PrAddr - TIMER_BASE;
    assign d_ofs     = PrAddr - DEV_BASE;
    assign timer_hit = t_ofs < 30'd3;
    assign dev_hit   = d_ofs < 30'(DEV_WORDS);
    assign full_word = PrBE == 4'b1111;

    assign dev_addr = d_ofs[DEV_AW-1:0];
    assign dev_wd   = PrWD;
    assign dev_be   = PrBE;
    assign dev_we   = IOWrite & dev_hit;
    assign dev_re   = IORead & dev_hit;

    timer_core u_timer (
        .clk       (clk),
        .reset     (reset),
        .ctrl_we   (IOWrite & timer_hit & full_word & (t_ofs[1:0] == CTRL_OFS)),
        .preset_we (IOWrite & timer_hit & full_word & (t_ofs[1:0] == PRESET_OFS)),
        .wd        (PrWD),
        .ctrl      (ctrl),
        .preset    (preset),
        .count     (count),
        .irq       (irq)
    );

    always_comb begin
        PrRD = '0;
        if (IORead) begin
            if (timer_hit) begin
                case (t_ofs[1:0])
                    CTRL_OFS:   PrRD = {28'b0, ctrl};
                    PRESET_OFS: PrRD = preset;
                    default:    PrRD = count;
                endcase
            end else if (dev_hit) begin
                PrRD = dev_rd;
            end
        end
    end

    assign HWInt = {ext_int, irq & ctrl[3]};

endmodule

// File: doc/io_bridge_timer.md
Name: io_bridge_timer

Overview:
System-side responder for the CPU's Pr* processor bus. The CPU drives PrAddr, PrWD, PrBE, IOWrite and IORead, and receives PrRD and HWInt. This block decodes the address into two targets: an internal countdown timer, and a window of external device registers that it passes straight through. It returns read data and assembles HWInt[7:2] from the timer interrupt plus external interrupt lines. It sits outside the CPU and serves the MEM stage.

Parameters:
TIMER_BASE, 30'h1FC0, word address of timer CTRL (byte address 0x7F00); PRESET is at +1, COUNT at +2
DEV_BASE, 30'h1FC4, first word address of the external device window (byte address 0x7F10)
DEV_WORDS, 4, number of words in the device window; must be a power of two

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
PrAddr  input  30  word address [31:2] from the CPU
PrWD  input  32  write data
PrBE  input  4  byte enables
IOWrite  input  1  write strobe, valid for one cycle
IORead  input  1  read qualifier
PrRD  output  32  read data, combinational
HWInt  output  6  interrupt vector [7:2]
ext_int  input  5  external interrupt sources, mapped to HWInt[7:3]
dev_addr  output  log2(DEV_WORDS)  word offset inside the device window
dev_wd  output  32  PrWD passthrough
dev_be  output  4  PrBE passthrough
dev_we  output  1  IOWrite qualified by a device-window hit
dev_re  output  1  IORead qualified by a device-window hit
dev_rd  input  32  device read data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset state: CTRL=0, PRESET=0, COUNT=0, FSM=IDLE, irq_pending=0.
- Outputs on reset: HWInt[2]=0, HWInt[7:3] follow ext_int, PrRD=0 unless a device-window read is in progress.
- Address decode:
  - timer hit when PrAddr is in TIMER_BASE..TIMER_BASE+2;
  - device hit when PrAddr is in DEV_BASE..DEV_BASE+DEV_WORDS-1;
  - any other address is unmapped: read returns 0, write is ignored.
- Reads: combinational, same cycle. Returned data by target:
  - CTRL returns {28'b0, IM, Mode[1:0], En};
  - PRESET returns PRESET;
  - COUNT returns COUNT;
  - device window returns dev_rd;
  - when IORead=0, PrRD=0.
- Timer writes:
  - honoured only when IOWrite=1 and PrBE==4'b1111; partial-byte writes to the timer are dropped;
  - the register updates at the next rising edge;
  - CTRL takes PrWD[3:0], PRESET takes PrWD;
  - COUNT is read-only; writes to it are ignored.
- Device writes: dev_we=IOWrite&hit, dev_addr=PrAddr low bits, byte enables passed through untouched.
- Timer FSM transitions:
  - IDLE: if En -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: if !En -> IDLE; else if COUNT>1, COUNT<=COUNT-1; else COUNT<=0, irq_pending<=1 -> INT.
  - INT, Mode 0 (one-shot): En<=0 -> IDLE.
  - INT, Mode 1 (auto-reload) -> LOAD.
  - Mode 2 and Mode 3 behave as Mode 0.
- Latency: with edge E0 being the CTRL write that sets En, irq_pending rises at edge E(max(PRESET,1)+2).
- irq_pending clearing:
  - Mode 0: cleared by any accepted CTRL write;
  - Mode 1: cleared automatically one cycle after it is set (single-cycle pulse).
- Interrupt output: HWInt[2]=irq_pending&IM. HWInt[7:3]=ext_int, combinational.
- Boundary cases:
  - PRESET=0 behaves like PRESET=1 (one CNT cycle).
  - CTRL write clearing En during CNT: IDLE at the next edge; COUNT freezes at its current value.
  - PRESET write during CNT: counting is unaffected; the new value is used at the next LOAD.
  - CTRL write in the same cycle the FSM enters INT: the FSM state update and irq_pending set still happen. The write's En is overridden by INT's En<=0 in Mode 0. The write's clear of irq_pending loses to the set.
  - Reset asserted mid-count returns everything to the reset values immediately.

Decomposition:
- Package bridge_pkg:
  - TIMER_BASE and DEV_BASE defaults;
  - register offsets CTRL_OFS=0, PRESET_OFS=1, COUNT_OFS=2;
  - enum type_timer_state {IDLE, LOAD, CNT, INT};
  - packed struct type_timer_ctrl {IM, Mode[1:0], En}.
- One sub-module, timer_core: owns the CTRL/PRESET/COUNT registers, the FSM and irq_pending. Its inputs are write enables and data from the decode logic. Its outputs are the register read values and irq.
- The top level holds only decode, the read mux and interrupt assembly.

Test Plan:
- Reset: assert reset mid-count (COUNT=5) -> COUNT, CTRL and irq read 0 at once; HWInt=={ext_int,0}.
- One-shot: write PRESET=3, then CTRL=4'b1001 at edge E0 -> COUNT reads 3,2,1 after E2..E4; HWInt[2]=1 after E5; En reads 0. A CTRL write of 0 clears HWInt[2].
- Auto-reload: PRESET=2, CTRL=4'b1011 -> HWInt[2] is a one-cycle pulse repeating every 4 cycles (LOAD, CNT, CNT, INT); COUNT reloads to 2.
- Disable mid-count: PRESET=10, enable, then write CTRL=0 when COUNT=6 -> COUNT holds 6, FSM IDLE, no interrupt.
- Partial write: write PRESET with PrBE=4'b0011 -> PRESET unchanged. Write to COUNT -> ignored. Read of unmapped 0x7F40 -> PrRD=0.
- Device window: write 32'hDEADBEEF to byte address 0x7F18 with PrBE=4'b0110 -> dev_we=1, dev_addr=2, dev_be=4'b0110. Read with dev_rd=32'h1234 -> PrRD=32'h1234. ext_int=5'b10101 -> HWInt[7:3]=5'b10101.
